// File: rtl/fuzz_stim_pkg.sv
// Shared definitions for the fuzz-harness stimulus generators: LCG constants,
// the LCG step function and the generator FSM state encoding.
package fuzz_stim_pkg;

    localparam logic [31:0] LCG_MULT = 32'h41C6_4E6D;
    localparam logic [31:0] LCG_INC  = 32'h0000_3039;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } stim_state_e;

    // One LCG step modulo 2^32; matches the software bench generator.
    function automatic logic [31:0] lcg_next(input logic [31:0] s,
                                             input logic [31:0] mult,
                                             input logic [31:0] inc);
        return s * mult + inc;
    endfunction

endpackage

// File: rtl/lcg32_step.sv
// Registered 32-bit LCG with synchronous load and step enable; load wins.
module lcg32_step
    import fuzz_stim_pkg::*;
#(
    parameter logic [31:0] MULT = LCG_MULT,
    parameter logic [31:0] INC  = LCG_INC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_i,
    input  logic        load_i,
    input  logic [31:0] load_val_i,
    output logic [31:0] state_o
);

    logic [31:0] state_q;
    logic [31:0] state_d;

    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = load_val_i;
        end else if (en_i) begin
            state_d = lcg_next(state_q, MULT, INC);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= 32'd0;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/lcg_stim_gen.sv
// Double-buffered LCG stimulus source: fills one 32-bit word per clock into a
// staging buffer and presents completed vectors on a valid/ready interface.
module lcg_stim_gen
    import fuzz_stim_pkg::*;
#(
    parameter int unsigned WIDTH = 261,
    parameter logic [31:0] MULT  = LCG_MULT,
    parameter logic [31:0] INC   = LCG_INC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      seed,
    input  logic [31:0]      num_vectors,
    output logic [WIDTH-1:0] vec_data,
    output logic             vec_valid,
    input  logic             vec_ready,
    output logic             busy,
    output logic             done,
    output logic [31:0]      vec_count
);

    localparam int unsigned NWORDS = (WIDTH + 31) / 32;
    localparam int unsigned SW     = NWORDS * 32;
    localparam int unsigned KW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NWORDS - 1);

    stim_state_e      state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] stage_q, stage_d;
    logic             stage_full_q, stage_full_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             valid_q, valid_d;
    logic [31:0]      num_q, num_d;
    logic [31:0]      gen_q, gen_d;
    logic [31:0]      count_q, count_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic             lcg_load_c;
    logic             lcg_en_c;
    logic [31:0]      lcg_state;
    logic [31:0]      word_c;
    logic             accept_c;
    logic             xfer_c;
    logic             wr_c;

    lcg32_step #(
        .MULT (MULT),
        .INC  (INC)
    ) u_lcg (
        .clk        (clk),
        .rst        (rst),
        .en_i       (lcg_en_c),
        .load_i     (lcg_load_c),
        .load_val_i (seed),
        .state_o    (lcg_state)
    );

    // The word written is the post-step state, so it is the LCG's next value.
    assign word_c = lcg_next(lcg_state, MULT, INC);

    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        stage_d      = stage_q;
        stage_full_d = stage_full_q;
        out_d        = out_q;
        valid_d      = valid_q;
        num_d        = num_q;
        gen_d        = gen_q;
        count_d      = count_q;
        done_d       = done_q;
        busy_d       = busy_q;
        lcg_load_c   = 1'b0;
        lcg_en_c     = 1'b0;
        xfer_c       = 1'b0;
        wr_c         = 1'b0;
        accept_c     = valid_q && vec_ready;

        if (accept_c) begin
            valid_d = 1'b0;
            if (count_q != num_q) begin
                count_d = count_q + 32'd1;
            end
        end

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    lcg_load_c   = 1'b1;
                    num_d        = num_vectors;
                    gen_d        = 32'd0;
                    count_d      = 32'd0;
                    k_d          = '0;
                    stage_full_d = 1'b0;
                    done_d       = (num_vectors == 32'd0);
                    busy_d       = (num_vectors != 32'd0);
                    state_d      = (num_vectors == 32'd0) ? DONE : FILL;
                end
            end

            FILL: begin
                // Move staging to output when output is free or leaving now.
                xfer_c = stage_full_q && (!valid_q || accept_c);
                wr_c   = (gen_q != num_q) && (!stage_full_q || xfer_c);

                if (xfer_c) begin
                    out_d        = stage_q;
                    valid_d      = 1'b1;
                    stage_full_d = 1'b0;
                    if (gen_q == num_q) begin
                        state_d = DRAIN;
                    end
                end

                if (wr_c) begin
                    lcg_en_c = 1'b1;
                    stage_d  = (stage_q & ~WIDTH'(SW'(32'hFFFF_FFFF) << (32 * int'(k_q))))
                             | WIDTH'(SW'(word_c) << (32 * int'(k_q)));
                    if (k_q == K_LAST) begin
                        k_d          = '0;
                        stage_full_d = 1'b1;
                        gen_d        = gen_q + 32'd1;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end

            DRAIN: begin
                if (accept_c) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            k_q          <= '0;
            stage_q      <= '0;
            stage_full_q <= 1'b0;
            out_q        <= '0;
            valid_q      <= 1'b0;
            num_q        <= 32'd0;
            gen_q        <= 32'd0;
            count_q      <= 32'd0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            stage_q      <= stage_d;
            stage_full_q <= stage_full_d;
            out_q        <= out_d;
            valid_q      <= valid_d;
            num_q        <= num_d;
            gen_q        <= gen_d;
            count_q      <= count_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
        end
    end

    assign vec_data  = out_q;
    assign vec_valid = valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign vec_count = count_q;

endmodule

// File: tb/tb_lcg_stim_gen.sv
// Scoreboard bench for lcg_stim_gen: expected vectors are queued at start and
// popped on every handshake; scenario tasks add their own inline checks.
module tb_lcg_stim_gen;

    localparam int unsigned WIDTH = 261;
    localparam int unsigned NW    = (WIDTH + 31) / 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [31:0]      seed = 32'd0;
    logic [31:0]      num_vectors = 32'd0;
    logic [WIDTH-1:0] vec_data;
    logic             vec_valid;
    logic             vec_ready = 1'b0;
    logic             busy;
    logic             done;
    logic [31:0]      vec_count;

    int total = 0;
    int bad   = 0;
    int hs_cnt = 0;
    logic [WIDTH-1:0] sb[$];
    bit               hold_pend = 1'b0;
    logic [WIDTH-1:0] held;

    lcg_stim_gen #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .seed        (seed),
        .num_vectors (num_vectors),
        .vec_data    (vec_data),
        .vec_valid   (vec_valid),
        .vec_ready   (vec_ready),
        .busy        (busy),
        .done        (done),
        .vec_count   (vec_count)
    );

    always #5 clk = ~clk;

    // Software model of the bench generator: NW LCG steps, word k at bits 32k.
    function automatic logic [WIDTH-1:0] model_vec(input logic [31:0] st_in,
                                                   output logic [31:0] st_out);
        logic [NW*32-1:0] pad;
        logic [31:0]      st;
        st  = st_in;
        pad = '0;
        for (int k = 0; k < NW; k++) begin
            st = st * 32'h41C6_4E6D + 32'h0000_3039;
            pad[32*k +: 32] = st;
        end
        st_out = st;
        return WIDTH'(pad);
    endfunction

    // Advance one clock; scoreboard the handshake about to happen and check hold.
    task automatic cycle();
        logic [WIDTH-1:0] exp_v;
        if (!rst && vec_valid === 1'b1 && vec_ready === 1'b1) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL sb_underflow: handshake with empty queue, data=%h", vec_data);
            end else begin
                exp_v = sb.pop_front();
                if (vec_data !== exp_v) begin
                    bad++;
                    $display("FAIL sb_data #%0d: got %h want %h", hs_cnt, vec_data, exp_v);
                end
            end
            hs_cnt++;
        end
        hold_pend = !rst && vec_valid === 1'b1 && vec_ready === 1'b0;
        held      = vec_data;
        @(negedge clk);
        #2;
        if (hold_pend && !rst) begin
            total++;
            if (vec_valid !== 1'b1 || vec_data !== held) begin
                bad++;
                $display("FAIL hold: valid=%b data=%h want valid=1 data=%h", vec_valid, vec_data, held);
            end
        end
    endtask

    // Issue a start; on return the accepting edge has passed (cycle 0).
    task automatic kick(input logic [31:0] s, input logic [31:0] n);
        logic [31:0] st;
        logic [31:0] st_n;
        cycle();
        start       = 1'b1;
        seed        = s;
        num_vectors = n;
        st = s;
        for (int i = 0; i < int'(n); i++) begin
            sb.push_back(model_vec(st, st_n));
            st = st_n;
        end
        cycle();
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        while (cyc < limit) begin
            cycle();
            cyc++;
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle();
        cycle();
        total++;
        if (vec_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl: valid=%b busy=%b done=%b want 0 0 0", vec_valid, busy, done);
        end
        total++;
        if (vec_data !== '0 || vec_count !== 32'd0) begin
            bad++;
            $display("FAIL reset_data: data=%h count=%0d want 0 0", vec_data, vec_count);
        end
        rst = 1'b0;
        cycle();
    endtask

    task automatic test_basic();
        int c;
        vec_ready = 1'b1;
        kick(32'd0, 32'd1);
        total++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL basic_busy: busy=%b done=%b want 1 0", busy, done);
        end
        c = 0;
        while (vec_valid !== 1'b1 && c < 40) begin
            cycle();
            c++;
        end
        total++;
        if (c != NW + 1) begin
            bad++;
            $display("FAIL basic_latency: first valid at cycle %0d want %0d", c, NW + 1);
        end
        total++;
        if (vec_data[31:0] !== 32'h0000_3039 || vec_data[63:32] !== 32'hD3DC_167E) begin
            bad++;
            $display("FAIL basic_words: w0=%h w1=%h want 00003039 d3dc167e", vec_data[31:0], vec_data[63:32]);
        end
        cycle();
        total++;
        if (done !== 1'b1 || vec_count !== 32'd1 || vec_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL basic_done: done=%b count=%0d valid=%b busy=%b want 1 1 0 0", done, vec_count, vec_valid, busy);
        end
    endtask

    task automatic test_cross_check();
        int  cyc;
        bit  ok;
        int  hs0;
        vec_ready = 1'b1;
        hs0 = hs_cnt;
        kick(32'd983297492, 32'd100);
        wait_done(3000, cyc, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL xchk_timeout: done not seen after %0d cycles", cyc);
        end
        total++;
        if (cyc != (NW + 1) + NW * 99 + 1) begin
            bad++;
            $display("FAIL xchk_rate: done at cycle %0d want %0d", cyc, (NW + 1) + NW * 99 + 1);
        end
        total++;
        if (vec_count !== 32'd100 || hs_cnt - hs0 != 100 || sb.size() != 0) begin
            bad++;
            $display("FAIL xchk_count: count=%0d hs=%0d left=%0d want 100 100 0", vec_count, hs_cnt - hs0, sb.size());
        end
    endtask

    task automatic test_backpressure();
        int c;
        int cyc;
        bit ok;
        vec_ready = 1'b0;
        kick(32'd0, 32'd3);
        c = 0;
        while (vec_valid !== 1'b1 && c < 40) begin
            cycle();
            c++;
        end
        total++;
        if (c != NW + 1) begin
            bad++;
            $display("FAIL bp_latency: first valid at cycle %0d want %0d", c, NW + 1);
        end
        for (int i = 0; i < 20; i++) cycle();
        total++;
        if (vec_valid !== 1'b1 || vec_count !== 32'd0 || vec_data[31:0] !== 32'h0000_3039) begin
            bad++;
            $display("FAIL bp_stalled: valid=%b count=%0d w0=%h want 1 0 00003039", vec_valid, vec_count, vec_data[31:0]);
        end
        vec_ready = 1'b1;
        cycle();
        total++;
        if (vec_valid !== 1'b1 || vec_count !== 32'd1) begin
            bad++;
            $display("FAIL bp_no_bubble: valid=%b count=%0d want 1 1", vec_valid, vec_count);
        end
        wait_done(100, cyc, ok);
        total++;
        if (!ok || vec_count !== 32'd3 || sb.size() != 0) begin
            bad++;
            $display("FAIL bp_done: done_seen=%b count=%0d left=%0d want 1 3 0", ok, vec_count, sb.size());
        end
    endtask

    task automatic test_zero_length();
        vec_ready = 1'b1;
        kick(32'hDEAD_BEEF, 32'd0);
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || vec_count !== 32'd0) begin
            bad++;
            $display("FAIL zero_done: done=%b busy=%b count=%0d want 1 0 0", done, busy, vec_count);
        end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (vec_valid !== 1'b0) begin
                bad++;
                $display("FAIL zero_valid: valid=%b at cycle %0d want 0", vec_valid, i);
            end
            cycle();
        end
    endtask

    task automatic test_mid_reset();
        int c;
        int cyc;
        bit ok;
        vec_ready = 1'b1;
        kick(32'd0, 32'd3);
        for (int i = 0; i < 13; i++) cycle();
        rst = 1'b1;
        #1;
        total++;
        if (vec_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || vec_count !== 32'd0 || vec_data !== '0) begin
            bad++;
            $display("FAIL rst_async: valid=%b busy=%b done=%b count=%0d data=%h want all 0", vec_valid, busy, done, vec_count, vec_data);
        end
        sb.delete();
        cycle();
        cycle();
        rst = 1'b0;
        kick(32'd0, 32'd1);
        c = 0;
        while (vec_valid !== 1'b1 && c < 40) begin
            cycle();
            c++;
        end
        total++;
        if (c != NW + 1 || vec_data[31:0] !== 32'h0000_3039) begin
            bad++;
            $display("FAIL rst_restart: first valid cycle %0d w0=%h want %0d 00003039", c, vec_data[31:0], NW + 1);
        end
        wait_done(40, cyc, ok);
        total++;
        if (!ok || vec_count !== 32'd1) begin
            bad++;
            $display("FAIL rst_done: done_seen=%b count=%0d want 1 1", ok, vec_count);
        end
    endtask

    task automatic test_ignored_start();
        int cyc;
        bit ok;
        int hs0;
        vec_ready = 1'b1;
        hs0 = hs_cnt;
        kick(32'h1234_5678, 32'd2);
        for (int i = 0; i < 3; i++) cycle();
        start       = 1'b1;
        seed        = 32'hCAFE_F00D;
        num_vectors = 32'd5;
        cycle();
        start = 1'b0;
        total++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL ign_busy: busy=%b done=%b want 1 0", busy, done);
        end
        wait_done(200, cyc, ok);
        total++;
        if (!ok || 4 + cyc != 2 * NW + 2) begin
            bad++;
            $display("FAIL ign_timing: done_seen=%b at cycle %0d want cycle %0d", ok, 4 + cyc, 2 * NW + 2);
        end
        total++;
        if (vec_count !== 32'd2 || hs_cnt - hs0 != 2 || sb.size() != 0) begin
            bad++;
            $display("FAIL ign_count: count=%0d hs=%0d left=%0d want 2 2 0", vec_count, hs_cnt - hs0, sb.size());
        end
        for (int i = 0; i < 4; i++) cycle();
        total++;
        if (vec_valid !== 1'b0 || done !== 1'b1) begin
            bad++;
            $display("FAIL ign_quiet: valid=%b done=%b want 0 1", vec_valid, done);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_cross_check();
        test_backpressure();
        test_zero_length();
        test_mid_reset();
        test_ignored_start();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lcg_stim_gen.md
Name: lcg_stim_gen

Overview:
- Synthesizable upstream stimulus source for the fuzz harness: produces the wide `in_flat` vector for the DUT under test.
- Uses the same 32-bit LCG and word-fill order as the software bench, so RTL-driven and bench-driven runs see identical stimulus for a given seed.
- Fills one 32-bit word per clock into a staging buffer, then presents completed vectors on a valid/ready interface.
- Double-buffered: the next vector fills while the current one waits for its consumer.

Parameters:
- WIDTH, 261, stimulus vector width in bits; must be >= 1.
- MULT, 32'h41C64E6D, LCG multiplier.
- INC, 32'h3039, LCG increment.
- NWORDS, (WIDTH+31)/32, derived localparam (9 at default), LCG steps per vector.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; asynchronous, active-high.
- start  input  1  begin a run; sampled only in IDLE or DONE.
- seed  input  32  initial LCG state, captured on accepted start.
- num_vectors  input  32  vectors to emit in this run, captured on accepted start.
- vec_data  output  WIDTH  current stimulus vector.
- vec_valid  output  1  vec_data holds a vector not yet accepted.
- vec_ready  input  1  consumer accepts vec_data when vec_valid && vec_ready at posedge.
- busy  output  1  high in FILL/DRAIN.
- done  output  1  level; high from end of run until next accepted start.
- vec_count  output  32  vectors accepted so far in this run.

Behaviour:
- Reset (async assert, any state) forces:
  - all outputs to 0, FSM to IDLE;
  - LCG state 0, fill word index 0;
  - both buffers empty and zeroed.
- LCG step: state_next = (state*MULT + INC) mod 2^32. The word written is state_next.
- Word mapping:
  - word k goes to bits [32k+31:32k];
  - the last word is truncated to bits [WIDTH-1:32(NWORDS-1)] using the low-order bits of state_next.
- FSM states:
  - IDLE: start=1 -> capture seed and num_vectors; clear vec_count and done. If num_vectors==0, go to DONE (done=1 next cycle, vec_valid never asserted). Otherwise go to FILL.
  - FILL:
    - Each cycle the staging buffer is not full, perform one LCG step and write word k; k++.
    - After word NWORDS-1 is written, the staging buffer is full.
    - When the staging buffer is full and the output buffer is empty, or is being accepted this cycle, transfer staging to the output register. vec_valid=1 next cycle; k resets to 0; the next fill starts in that same cycle.
    - Stop generating once (vectors generated) == num_vectors, then go to DRAIN.
  - DRAIN: wait for the final handshake, then go to DONE.
  - DONE: done=1, busy=0. start=1 behaves as in IDLE.
- Latency: first vec_valid is asserted NWORDS+1 cycles after the accepted start edge.
- Throughput: sustained rate with vec_ready tied high is one vector per NWORDS cycles.
- Output hold: vec_data is stable while vec_valid && !vec_ready.
- Backpressure:
  - With the staging buffer full and the output buffer held, LCG state and k freeze.
  - No step is lost or repeated.
- vec_count increments on each handshake; it saturates at num_vectors (never exceeds it).
- start in FILL or DRAIN is ignored.
- Simultaneous transfer and accept in the same cycle:
  - the accepted vector leaves;
  - the staged vector enters;
  - vec_valid stays 1 without a bubble.
- Reset mid-run discards partial and buffered vectors. The next run restarts from the new seed.

Decomposition:
- Shared package fuzz_stim_pkg holds:
  - LCG_MULT and LCG_INC constants;
  - the lcg_next function;
  - a state enum typedef {IDLE, FILL, DRAIN, DONE}.
- One natural sub-module: lcg32_step. It is a registered 32-bit LCG with enable and load and is reusable by other harness blocks.
- Buffer and FSM logic stay in the top module.

Test Plan:
1. Basic fill: seed=0, num_vectors=1, vec_ready=1.
   - Required: vec_data[31:0]=32'h00003039, vec_data[63:32]=32'hD3DC167E.
   - Required: vec_valid asserted exactly one cycle after fill completes; then done=1 and vec_count=1.
2. Cross-check: seed=983297492, num_vectors=100, vec_ready=1.
   - Required: every vec_data matches a software model of the bench generator word-for-word, including the 5-bit top word taken from state[4:0].
   - Required: 100 handshakes, then done=1.
3. Backpressure: seed=0, num_vectors=3, vec_ready low for 20 cycles after the first valid.
   - Required: vec_data is held constant throughout; the second vector is staged and LCG state frozen.
   - Required: after release, vectors 2 and 3 match the no-stall sequence, with no bubble between vectors 1 and 2.
4. Zero-length run: start with num_vectors=0.
   - Required: vec_valid never asserted; done=1 on the next cycle; vec_count=0.
5. Mid-run reset and restart: assert rst during word 4 of vector 2, then restart with seed=0.
   - Required: all outputs are 0 within the same timestep as rst assertion.
   - Required: after restart, the first vector again begins with 32'h00003039.
6. Ignored start: pulse start while busy.
   - Required: no state change; the run completes with the original vector count.
